fp_stage_sequencer: RTL and testbench

Parametrised stage-enable sequencer for the pipelined floating-point units (divider first, then multiplier and adder). It drives one one-hot enable per pipeline stage and walks through NUM_STAGES stages per operation. It adds a start/ready handshake, stall, abort, single-pass or free-running mode, a completion pulse and a pass counter. It sits between the operand-capture logic and the stage registers of each pipelined datapath.

---
 rtl/fp_pipe_pkg.sv | 22 ++
 rtl/onehot_decoder.sv | 20 ++
 rtl/fp_stage_sequencer.sv | 115 +++++++++++
 tb/tb_fp_stage_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pipe_pkg.sv
// Shared definitions for the pipelined floating-point stage sequencers.
`timescale 1ns/1ps
package fp_pipe_pkg;

  // Sequencer state: IDLE waits for a pass request, RUN walks the stages.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Legal range for the number of sequenced stages.
  localparam int unsigned MIN_STAGES = 2;
  localparam int unsigned MAX_STAGES = 16;

  // Width of a stage index; at least one bit even for tiny pipelines.
  function automatic int idx_width(input int num_stages);
    int w;
    w = $clog2(num_stages);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Index to one-hot decoder with a global enable, shared by pipelined units.
`timescale 1ns/1ps
module onehot_decoder #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N-1:0]     onehot_o
);

  // Bit i is set only when enabled and the index equals i.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      onehot_o[i] = en_i && (idx_i == IDX_W'(i));
    end
  end

endmodule

// File: rtl/fp_stage_sequencer.sv
// Stage-enable sequencer: one-hot enable per pipeline stage, start/ready
// handshake, stall, abort, single-pass or free-running mode, done pulse and
// a pass counter.
//
// Handshake: a start is taken on a rising edge where start && start_ready.
// start_ready depends only on fsm_enable, stall and state (never on start):
// high in IDLE while enabled, and in the last unstalled RUN cycle when not
// free-running (back-to-back pass without a bubble).
`timescale 1ns/1ps
module fp_stage_sequencer
  import fp_pipe_pkg::*;
#(
  parameter int NUM_STAGES   = 3,
  parameter bit AUTO_RESTART = 1'b0,
  parameter int CNT_W        = 16,
  localparam int IDX_W       = idx_width(NUM_STAGES)
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  fsm_enable,
  input  logic                  start,
  input  logic                  stall,
  output logic                  start_ready,
  output logic [NUM_STAGES-1:0] enable_stage,
  output logic [IDX_W-1:0]      stage_index,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      pass_count,
  output seq_state_t            dbg_state
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STAGES - 1);

  if ((NUM_STAGES < MIN_STAGES) || (NUM_STAGES > MAX_STAGES)) begin : g_range_check
    $error("fp_stage_sequencer: NUM_STAGES out of legal range");
  end

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, stage index, done pulse and pass counter registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and handshake; abort beats stall, stall beats advance.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    start_ready = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = fsm_enable;
        if (fsm_enable && (start || AUTO_RESTART)) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (!fsm_enable) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (!stall) begin
          if (idx_q != LAST) begin
            idx_d = idx_q + 1'b1;
          end else begin
            done_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            idx_d  = '0;
            if (!AUTO_RESTART) begin
              start_ready = 1'b1;
              if (!start) begin
                state_d = IDLE;
              end
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  onehot_decoder #(
    .N     (NUM_STAGES),
    .IDX_W (IDX_W)
  ) u_decoder (
    .idx_i    (idx_q),
    .en_i     ((state_q == RUN) && !stall),
    .onehot_o (enable_stage)
  );

  assign stage_index = idx_q;
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign pass_count  = cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fp_stage_sequencer.sv
// Directed bench for fp_stage_sequencer: three instances (3 stages single
// pass, 4 stages single pass, 5 stages free-running) with a per-cycle
// expected queue.
`timescale 1ns/1ps
module tb_fp_stage_sequencer;
  import fp_pipe_pkg::*;

  // Packed observation: {ready, busy, done, idx[3:0], enable[7:0], count[3:0]}
  localparam int W = 19;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic en3 = 1'b0, en4 = 1'b0, en5 = 1'b0;

  logic        rdy3, busy3, done3;
  logic [2:0]  es3;
  logic [1:0]  ix3;
  logic [15:0] cnt3;
  seq_state_t  st3;

  logic        rdy4, busy4, done4;
  logic [3:0]  es4;
  logic [1:0]  ix4;
  logic [15:0] cnt4;
  seq_state_t  st4;

  logic        rdy5, busy5, done5;
  logic [4:0]  es5;
  logic [2:0]  ix5;
  logic [15:0] cnt5;
  seq_state_t  st5;

  fp_stage_sequencer #(.NUM_STAGES(3), .AUTO_RESTART(1'b0), .CNT_W(16)) dut3 (
    .clk_in(clk), .reset(reset), .fsm_enable(en3), .start(start), .stall(stall),
    .start_ready(rdy3), .enable_stage(es3), .stage_index(ix3), .busy(busy3),
    .done(done3), .pass_count(cnt3), .dbg_state(st3));

  fp_stage_sequencer #(.NUM_STAGES(4), .AUTO_RESTART(1'b0), .CNT_W(16)) dut4 (
    .clk_in(clk), .reset(reset), .fsm_enable(en4), .start(start), .stall(stall),
    .start_ready(rdy4), .enable_stage(es4), .stage_index(ix4), .busy(busy4),
    .done(done4), .pass_count(cnt4), .dbg_state(st4));

  fp_stage_sequencer #(.NUM_STAGES(5), .AUTO_RESTART(1'b1), .CNT_W(16)) dut5 (
    .clk_in(clk), .reset(reset), .fsm_enable(en5), .start(start), .stall(stall),
    .start_ready(rdy5), .enable_stage(es5), .stage_index(ix5), .busy(busy5),
    .done(done5), .pass_count(cnt5), .dbg_state(st5));

  logic [W-1:0] obs3, obs4, obs5;
  assign obs3 = {rdy3, busy3, done3, 2'b0, ix3, 5'b0, es3, cnt3[3:0]};
  assign obs4 = {rdy4, busy4, done4, 2'b0, ix4, 4'b0, es4, cnt4[3:0]};
  assign obs5 = {rdy5, busy5, done5, 1'b0, ix5, 3'b0, es5, cnt5[3:0]};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] mk(input logic r, input logic b, input logic d,
                                      input logic [3:0] ix, input logic [7:0] e,
                                      input logic [3:0] c);
    return {r, b, d, ix, e, c};
  endfunction

  task automatic chk(input int sel, input string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] got;
    exp_v = exp_q.pop_front();
    got   = (sel == 3) ? obs3 : (sel == 4) ? obs4 : obs5;
    checks++;
    assert (got === exp_v) else begin
      errors++;
      $error("FAIL %s dut%0d got rdy/busy/done/idx/en/cnt=%h expected=%h",
             tag, sel, got, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: drive inputs after the edge, compare at the falling edge.
  task automatic cyc(input int sel, input logic st, input logic sl,
                     input logic [W-1:0] e, input string tag);
    start = st;
    stall = sl;
    exp_q.push_back(e);
    @(negedge clk);
    chk(sel, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    stall = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state while reset is held.
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 8'h00, 0)); chk(3, "rst3");
    exp_q.push_back(mk(0, 0, 0, 0, 8'h00, 0)); chk(4, "rst4");
    exp_q.push_back(mk(0, 0, 0, 0, 8'h00, 0)); chk(5, "rst5");
    checks++;
    assert (st3 === IDLE && st4 === IDLE && st5 === IDLE) else begin
      errors++;
      $error("FAIL rst_state got %0d/%0d/%0d expected IDLE", st3, st4, st5);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single pass, 3 stages.
    en3 = 1'b1;
    cyc(3, 1, 0, mk(1, 0, 0, 0, 8'h00, 0), "sp_c0");
    cyc(3, 0, 0, mk(0, 1, 0, 0, 8'h01, 0), "sp_c1");
    cyc(3, 0, 0, mk(0, 1, 0, 1, 8'h02, 0), "sp_c2");
    cyc(3, 0, 0, mk(1, 1, 0, 2, 8'h04, 0), "sp_c3");
    cyc(3, 0, 0, mk(1, 0, 1, 0, 8'h00, 1), "sp_c4");
    cyc(3, 0, 0, mk(1, 0, 0, 0, 8'h00, 1), "sp_c5");

    // Stall, 4 stages: 2 cycles on stage 2, 1 cycle on stage 3.
    en3 = 1'b0;
    do_reset();
    en4 = 1'b1;
    cyc(4, 1, 0, mk(1, 0, 0, 0, 8'h00, 0), "st_c0");
    cyc(4, 0, 0, mk(0, 1, 0, 0, 8'h01, 0), "st_c1");
    cyc(4, 0, 0, mk(0, 1, 0, 1, 8'h02, 0), "st_c2");
    cyc(4, 0, 1, mk(0, 1, 0, 2, 8'h00, 0), "st_c3");
    cyc(4, 0, 1, mk(0, 1, 0, 2, 8'h00, 0), "st_c4");
    cyc(4, 0, 0, mk(0, 1, 0, 2, 8'h04, 0), "st_c5");
    cyc(4, 0, 1, mk(0, 1, 0, 3, 8'h00, 0), "st_c6");
    cyc(4, 0, 0, mk(1, 1, 0, 3, 8'h08, 0), "st_c7");
    cyc(4, 0, 0, mk(1, 0, 1, 0, 8'h00, 1), "st_c8");
    cyc(4, 0, 0, mk(1, 0, 0, 0, 8'h00, 1), "st_c9");

    // Back-to-back, 3 passes with start held.
    en4 = 1'b0;
    do_reset();
    en3 = 1'b1;
    cyc(3, 1, 0, mk(1, 0, 0, 0, 8'h00, 0), "bb_c0");
    cyc(3, 1, 0, mk(0, 1, 0, 0, 8'h01, 0), "bb_c1");
    cyc(3, 1, 0, mk(0, 1, 0, 1, 8'h02, 0), "bb_c2");
    cyc(3, 1, 0, mk(1, 1, 0, 2, 8'h04, 0), "bb_c3");
    cyc(3, 1, 0, mk(0, 1, 1, 0, 8'h01, 1), "bb_c4");
    cyc(3, 1, 0, mk(0, 1, 0, 1, 8'h02, 1), "bb_c5");
    cyc(3, 1, 0, mk(1, 1, 0, 2, 8'h04, 1), "bb_c6");
    cyc(3, 1, 0, mk(0, 1, 1, 0, 8'h01, 2), "bb_c7");
    cyc(3, 1, 0, mk(0, 1, 0, 1, 8'h02, 2), "bb_c8");
    cyc(3, 0, 0, mk(1, 1, 0, 2, 8'h04, 2), "bb_c9");
    cyc(3, 0, 0, mk(1, 0, 1, 0, 8'h00, 3), "bb_c10");

    // Abort during stage 1; pass_count stays at 3.
    cyc(3, 1, 0, mk(1, 0, 0, 0, 8'h00, 3), "ab_c0");
    cyc(3, 0, 0, mk(0, 1, 0, 0, 8'h01, 3), "ab_c1");
    en3 = 1'b0;
    cyc(3, 0, 0, mk(0, 1, 0, 1, 8'h02, 3), "ab_c2");
    cyc(3, 0, 0, mk(0, 0, 0, 0, 8'h00, 3), "ab_c3");
    en3 = 1'b1;
    cyc(3, 0, 0, mk(1, 0, 0, 0, 8'h00, 3), "ab_c4");
    cyc(3, 0, 0, mk(1, 0, 0, 0, 8'h00, 3), "ab_c5");

    // Free-running, 5 stages, 20 cycles without start.
    en3 = 1'b0;
    do_reset();
    en5 = 1'b1;
    cyc(5, 0, 0, mk(1, 0, 0, 0, 8'h00, 0), "fr_c0");
    for (int c = 1; c <= 20; c++) begin
      logic [7:0] e;
      logic       d;
      e = 8'(1 << ((c - 1) % 5));
      d = (c > 1) && (((c - 1) % 5) == 0);
      cyc(5, 0, 0, mk(0, 1, d, 4'((c - 1) % 5), e, 4'((c - 1) / 5)), "fr_run");
    end
    en5 = 1'b0;

    // Async reset mid-cycle on a stalled stage 2, after one full pass.
    do_reset();
    en4 = 1'b1;
    cyc(4, 1, 0, mk(1, 0, 0, 0, 8'h00, 0), "ar_p_c0");
    cyc(4, 0, 0, mk(0, 1, 0, 0, 8'h01, 0), "ar_p_c1");
    cyc(4, 0, 0, mk(0, 1, 0, 1, 8'h02, 0), "ar_p_c2");
    cyc(4, 0, 0, mk(0, 1, 0, 2, 8'h04, 0), "ar_p_c3");
    cyc(4, 0, 0, mk(1, 1, 0, 3, 8'h08, 0), "ar_p_c4");
    cyc(4, 0, 0, mk(1, 0, 1, 0, 8'h00, 1), "ar_p_c5");
    cyc(4, 1, 0, mk(1, 0, 0, 0, 8'h00, 1), "ar_c0");
    cyc(4, 0, 0, mk(0, 1, 0, 0, 8'h01, 1), "ar_c1");
    cyc(4, 0, 0, mk(0, 1, 0, 1, 8'h02, 1), "ar_c2");
    cyc(4, 0, 1, mk(0, 1, 0, 2, 8'h00, 1), "ar_c3");
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(mk(1, 0, 0, 0, 8'h00, 0));
    chk(4, "ar_async");
    checks++;
    assert (st4 === IDLE) else begin
      errors++;
      $error("FAIL ar_state got %0d expected IDLE", st4);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(4, 1, 0, mk(1, 0, 0, 0, 8'h00, 0), "rs_c0");
    cyc(4, 0, 0, mk(0, 1, 0, 0, 8'h01, 0), "rs_c1");
    cyc(4, 0, 0, mk(0, 1, 0, 1, 8'h02, 0), "rs_c2");
    cyc(4, 0, 0, mk(0, 1, 0, 2, 8'h04, 0), "rs_c3");
    cyc(4, 0, 0, mk(1, 1, 0, 3, 8'h08, 0), "rs_c4");
    cyc(4, 0, 0, mk(1, 0, 1, 0, 8'h00, 1), "rs_c5");

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
